md_sequencer: RTL
=================

Name: md_sequencer

Overview:
- Sequences the iterative Booth multiplier and iterative divider on behalf of the pipeline's execute stage.
- Accepts one mult/div request, captures its operands and destination tag, and pulses the unit's start input for exactly one cycle.
- Stalls the pipeline while the unit iterates, then presents a held writeback (result, rd, exception) until it is acknowledged.
- Handles flush mid-operation and, optionally, a watchdog timeout.

Parameters:
- WIDTH, 32, operand/result width
- MAX_CYCLES, 40, watchdog limit in cycles from start pulse (timeout feature only)
- CNT_W, 6, counter width; must satisfy 2^CNT_W > MAX_CYCLES

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  execute stage presents a mult/div op
- req_is_div  in  1  0 = multiply, 1 = divide
- req_a  in  WIDTH  multiplicand / dividend
- req_b  in  WIDTH  multiplier / divisor
- req_rd  in  5  destination register
- flush  in  1  squash in-flight op
- busy  out  1  stall to pipeline
- start_mult  out  1  one-cycle start to multiplier (its newMult)
- start_div  out  1  one-cycle start to divider
- op_a  out  WIDTH  registered operand A to units
- op_b  out  WIDTH  registered operand B to units
- mult_result  in  WIDTH  multiplier data_out
- mult_ready  in  1  multiplier result_ready
- mult_ovf  in  1  multiplier ovf
- div_result  in  WIDTH  divider quotient
- div_ready  in  1  divider ready
- div_exc  in  1  divider exception (divide by zero)
- wb_valid  out  1  writeback held valid
- wb_rd  out  5  destination tag
- wb_data  out  WIDTH  result
- wb_exc  out  1  ovf / div-by-zero / timeout
- wb_ack  in  1  writeback consumed

Behaviour:
- Reset (async): state IDLE; all outputs 0; counter 0; op_a/op_b/wb_* 0.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - req_valid & ~flush -> capture a, b, rd, is_div; go to START.
  - busy = 0.
- START:
  - Exactly one cycle.
  - start_mult = ~is_div; start_div = is_div; operands already stable on op_a/op_b.
  - Counter cleared; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - Selected unit's ready is ignored in the first WAIT cycle (stale-ready guard); from the second WAIT cycle on, ready is honoured.
  - On ready: latch result into wb_data; latch wb_exc = mult_ovf (mult) or div_exc (div); go to DONE.
  - The non-selected unit's ready is ignored.
- DONE:
  - wb_valid = 1; wb_rd/wb_data/wb_exc held stable.
  - wb_ack -> IDLE the next cycle; wb_valid drops in that same edge.
- busy:
  - 1 in START and WAIT.
  - 1 in DONE while ~wb_ack.
  - 0 in IDLE.
  - Combinational 1 in IDLE when req_valid, so the requesting instruction holds.
- Latency: request accept edge -> START -> WAIT (N cycles) -> DONE. wb_valid appears 2 + N cycles after acceptance; N ≥ 2.
- No new request is accepted before the DONE→IDLE transition (strictly one op in flight).
- Flush:
  - In START or WAIT: return to IDLE next edge, no writeback, start pulses suppressed. A start already issued is abandoned; the unit is restarted on the next request.
  - In DONE: drops wb_valid, back to IDLE.
  - Has priority over req_valid, ready and wb_ack in the same cycle.
- Reset mid-operation: immediate IDLE, outputs cleared regardless of state.

Optional Feature:
- MD_TIMEOUT_EN defined:
  - In WAIT, when counter reaches MAX_CYCLES without ready: go to DONE with wb_data = 0, wb_exc = 1.
  - If ready arrives in the same cycle the counter reaches MAX_CYCLES, ready wins.
- MD_TIMEOUT_EN undefined:
  - No watchdog; WAIT persists until ready or flush.
  - The counter may be omitted.

Test Plan:
- Multiply a=7, b=0xFFFFFFFD (-3), rd=5 -> single start_mult pulse; wb_valid with wb_data=0xFFFFFFEB, wb_rd=5, wb_exc=0; busy high until wb_ack.
- Multiply 0x00010000 × 0x00010000 -> wb_data=0x00000000, wb_exc=1 (mult_ovf).
- Divide 100 / 7 -> start_div only; wb_data=14. Divide 5 / 0 -> wb_exc=1.
- Flush 3 cycles after start -> IDLE next edge, wb_valid never rises. A following multiply 3×4 returns 12 with a fresh start pulse.
- wb_ack held low 5 cycles in DONE -> wb outputs stable, busy=1, a second req_valid is not accepted; ack -> IDLE, then the second request is accepted.
- With MD_TIMEOUT_EN, ready tied low -> wb_valid exactly MAX_CYCLES cycles after the first WAIT cycle, wb_data=0, wb_exc=1. Stale mult_ready=1 during the first WAIT cycle -> ignored.

Source files
------------

// File: rtl/md_sequencer.sv
// ============================================================================
// Module      : md_sequencer
// Description : Issues one multiply/divide op at a time to the iterative units,
//               stalls the pipeline meanwhile and holds the writeback until ack.
//               Optional watchdog enabled by defining MD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_is_div,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [4:0]       req_rd,
    input  logic             flush,
    output logic             busy,
    output logic             start_mult,
    output logic             start_div,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_ready,
    input  logic             mult_ovf,
    input  logic [WIDTH-1:0] div_result,
    input  logic             div_ready,
    input  logic             div_exc,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_exc,
    input  logic             wb_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_SAT = CNT_W'(MAX_CYCLES);

    state_t             r_state;
    state_t             w_next;
    logic               r_is_div;
    logic [4:0]         r_rd;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_wb_data;
    logic               r_wb_exc;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_unit_ready;
    logic [WIDTH-1:0]   w_unit_result;
    logic               w_unit_exc;
    logic               w_take;
    logic               w_timeout;

    assign w_accept      = (r_state == S_IDLE) && req_valid && !flush;
    assign w_unit_ready  = r_is_div ? div_ready  : mult_ready;
    assign w_unit_result = r_is_div ? div_result : mult_result;
    assign w_unit_exc    = r_is_div ? div_exc    : mult_ovf;

    // r_cnt is zero only in the first WAIT cycle, where ready may still be
    // left over from the previous operation.
    assign w_take = (r_state == S_WAIT) && !flush && (r_cnt != '0) && w_unit_ready;

`ifdef MD_TIMEOUT_EN
    assign w_timeout = (r_state == S_WAIT) && !flush && !w_take &&
                       (r_cnt == CNT_W'(MAX_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign op_a    = r_op_a;
    assign op_b    = r_op_b;
    assign wb_rd   = r_rd;
    assign wb_data = r_wb_data;
    assign wb_exc  = r_wb_exc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        wb_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = req_valid;
                if (w_accept) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                busy = 1'b1;
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    start_mult = !r_is_div;
                    start_div  = r_is_div;
                    w_next     = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (flush) begin
                    w_next = S_IDLE;
                end else if (w_take || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                wb_valid = 1'b1;
                busy     = !wb_ack;
                if (flush || wb_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div  <= 1'b0;
            r_rd      <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_wb_data <= '0;
            r_wb_exc  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_is_div <= req_is_div;
                r_rd     <= req_rd;
                r_op_a   <= req_a;
                r_op_b   <= req_b;
            end
            // Saturating so a long wait never wraps back into the guard cycle.
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT) && (r_cnt != C_CNT_SAT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_take) begin
                r_wb_data <= w_unit_result;
                r_wb_exc  <= w_unit_exc;
            end else if (w_timeout) begin
                r_wb_data <= '0;
                r_wb_exc  <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
